id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode (ID) and execute (EX) of the 5-stage RV32I core. It captures the operands delivered by the register file read ports together with the decode fields, and detects load-use hazards. On a hazard it freezes the front end and injects a bubble into EX. It also handles branch flushes from EX and hold requests from downstream multi-cycle units, and keeps a bubble counter for performance measurement.

## Interface
- CTRL_W, default 16: width of the opaque EX control bundle (ALU op, operand selects, branch type), passed through unchanged.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- valid_id  in  1  ID holds a real instruction.
- pc_id  in  32  PC of the ID instruction.
- rs1_id, rs2_id, rd_id  in  5 each  register indices.
- use_rs1_id, use_rs2_id  in  1 each  instruction actually reads rs1/rs2.
- read_data1_id, read_data2_id  in  32 each  register file read data, already bypassed from WB.
- imm_id  in  32  sign-extended immediate.
- ctrl_id  in  CTRL_W  EX control bundle.
- memread_id, memwrite_id, regwrite_id  in  1 each  memory and writeback enables.
- flush_ex  in  1  branch/jump taken in EX; kill the ID instruction.
- hold_ex  in  1  downstream not ready; freeze EX contents.
- stall_id  out  1  combinational; IF/ID must hold their registers this cycle.
- valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex, imm_ex, ctrl_ex, memread_ex, memwrite_ex, regwrite_ex  out  registered copies of the *_id inputs, with the same widths.
- bubble_count  out  32  number of bubbles inserted by load-use or flush.

## Operation
- Load-use hazard: asserted when valid_ex & memread_ex & rd_ex != 0 & valid_id and the ID instruction reads the loaded register.
  - The read check is (use_rs1_id & rs1_id == rd_ex) | (use_rs2_id & rs2_id == rd_ex).
  - A read of x0 never raises a hazard.
- stall_id = hold_ex | (load_use & ~flush_ex).
- Per-edge update, in strict priority order:
  1. ~rstn: all EX outputs go to 0 and bubble_count goes to 0.
  2. hold_ex: all EX registers keep their value. flush_ex is ignored, and the EX unit must keep asserting it until it is released. bubble_count is unchanged.
  3. flush_ex: a bubble is loaded and bubble_count increments.
  4. load_use: a bubble is loaded and bubble_count increments. The ID instruction is re-presented next cycle because stall_id is asserted.
  5. Otherwise: all *_ex registers load their *_id counterparts.
- Bubble definition: valid_ex, memread_ex, memwrite_ex and regwrite_ex are 0. All data/index fields and ctrl_ex are 0.
- If valid_id=0 in normal capture, the registers capture with valid_ex=0, and memread_ex, memwrite_ex and regwrite_ex are forced to 0. This does not count as a bubble.
- bubble_count wraps from 0xFFFFFFFF to 0.

## Timing
- Latency is 1 cycle from ID inputs to EX outputs.
- stall_id is purely combinational from the current EX registers and the ID inputs, with no registered delay. It is valid in the same cycle the hazard exists.
- A load followed immediately by a dependent instruction costs exactly 1 bubble. After that bubble, the load is in MEM and is forwarded by the EX forwarding network, which is outside this block.
- If flush_ex and load_use occur in the same cycle, flush wins: stall_id=0 and exactly one bubble is counted.
- A reset in mid-stall clears stall_id on the next cycle, because valid_ex becomes 0.

## Test plan
- Reset: drive rstn=0 for 2 cycles with random inputs. Required: all EX outputs 0, bubble_count=0, stall_id=hold_ex.
- Pass-through: valid_id=1, pc_id=0x100, rs1=3, rs2=4, rd=5, data1=0xAAAA5555, data2=0x12345678, imm=0xFFFFFFF0, regwrite=1. Required: identical values on EX outputs after 1 edge, stall_id=0.
- Load-use: EX holds lw x5 (memread_ex=1, rd_ex=5), ID holds add with use_rs1=1, rs1=5.
  - Required: stall_id=1 for 1 cycle, then a bubble in EX (valid_ex=0, regwrite_ex=0), bubble_count=1, then the add is captured.
  - Repeat with rd_ex=0 or use_rs1=0. Required: no stall.
- Flush vs load-use: same hazard plus flush_ex=1. Required: stall_id=0, bubble in EX next cycle, bubble_count increments by exactly 1.
- Hold: assert hold_ex for 3 cycles while ID changes and flush_ex=1. Required: EX outputs frozen, stall_id=1, bubble_count unchanged. After release with flush_ex still 1, one bubble is inserted.
- Counter wrap: preload bubble_count to 0xFFFFFFFF via 2^32-1 forced bubbles, or by a bench force. Required: the next bubble gives 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: captures decoded operands,
// detects load-use hazards, and handles flush/hold and bubble accounting.
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid_id,
    input  logic [31:0]       pc_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rd_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [31:0]       read_data1_id,
    input  logic [31:0]       read_data2_id,
    input  logic [31:0]       imm_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              memread_id,
    input  logic              memwrite_id,
    input  logic              regwrite_id,
    input  logic              flush_ex,
    input  logic              hold_ex,
    output logic              stall_id,
    output logic              valid_ex,
    output logic [31:0]       pc_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [31:0]       rs1_data_ex,
    output logic [31:0]       rs2_data_ex,
    output logic [31:0]       imm_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              memread_ex,
    output logic              memwrite_ex,
    output logic              regwrite_ex,
    output logic [31:0]       bubble_count
);

    logic reads_rd_ex;
    logic load_use;
    logic insert_bubble;

    // rd_ex != 0 keeps reads of x0 from ever stalling.
    assign reads_rd_ex   = (use_rs1_id && (rs1_id == rd_ex)) ||
                           (use_rs2_id && (rs2_id == rd_ex));
    assign load_use      = valid_ex && memread_ex && (rd_ex != 5'd0) && valid_id && reads_rd_ex;
    assign stall_id      = hold_ex | (load_use & ~flush_ex);
    assign insert_bubble = flush_ex || load_use;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_ex     <= 1'b0;
            pc_ex        <= '0;
            rs1_ex       <= '0;
            rs2_ex       <= '0;
            rd_ex        <= '0;
            rs1_data_ex  <= '0;
            rs2_data_ex  <= '0;
            imm_ex       <= '0;
            ctrl_ex      <= '0;
            memread_ex   <= 1'b0;
            memwrite_ex  <= 1'b0;
            regwrite_ex  <= 1'b0;
            bubble_count <= '0;
        end else if (!hold_ex) begin
            if (insert_bubble) begin
                valid_ex     <= 1'b0;
                pc_ex        <= '0;
                rs1_ex       <= '0;
                rs2_ex       <= '0;
                rd_ex        <= '0;
                rs1_data_ex  <= '0;
                rs2_data_ex  <= '0;
                imm_ex       <= '0;
                ctrl_ex      <= '0;
                memread_ex   <= 1'b0;
                memwrite_ex  <= 1'b0;
                regwrite_ex  <= 1'b0;
                bubble_count <= bubble_count + 32'd1;
            end else begin
                // An empty ID slot still captures its fields, but never its side effects.
                valid_ex     <= valid_id;
                pc_ex        <= pc_id;
                rs1_ex       <= rs1_id;
                rs2_ex       <= rs2_id;
                rd_ex        <= rd_id;
                rs1_data_ex  <= read_data1_id;
                rs2_data_ex  <= read_data2_id;
                imm_ex       <= imm_id;
                ctrl_ex      <= ctrl_id;
                memread_ex   <= memread_id & valid_id;
                memwrite_ex  <= memwrite_id & valid_id;
                regwrite_ex  <= regwrite_id & valid_id;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written hold,
// reset and wrap sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;

    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              valid_id;
    logic [31:0]       pc_id;
    logic [4:0]        rs1_id, rs2_id, rd_id;
    logic              use_rs1_id, use_rs2_id;
    logic [31:0]       read_data1_id, read_data2_id, imm_id;
    logic [CTRL_W-1:0] ctrl_id;
    logic              memread_id, memwrite_id, regwrite_id;
    logic              flush_ex, hold_ex;
    logic              stall_id;
    logic              valid_ex;
    logic [31:0]       pc_ex;
    logic [4:0]        rs1_ex, rs2_ex, rd_ex;
    logic [31:0]       rs1_data_ex, rs2_data_ex, imm_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic              memread_ex, memwrite_ex, regwrite_ex;
    logic [31:0]       bubble_count;

    id_ex_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rstn(rstn), .valid_id(valid_id), .pc_id(pc_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .read_data1_id(read_data1_id), .read_data2_id(read_data2_id),
        .imm_id(imm_id), .ctrl_id(ctrl_id),
        .memread_id(memread_id), .memwrite_id(memwrite_id), .regwrite_id(regwrite_id),
        .flush_ex(flush_ex), .hold_ex(hold_ex), .stall_id(stall_id),
        .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .ctrl_ex(ctrl_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .regwrite_ex(regwrite_ex), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [4:0]        rs1, rs2, rd;
        logic [31:0]       d1, d2, imm;
        logic [CTRL_W-1:0] ctrl;
        logic              mr, mw, rw;
    } ex_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2, mr, rw, flush;
        logic [31:0] d1, d2, imm;
        logic        exp_stall, exp_valid;
        logic [4:0]  exp_rd;
        logic [31:0] exp_pc, exp_bubbles;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    ex_t         model_ex = '0;
    logic [31:0] model_cnt = '0;
    vec_t        vecs[13];

    // Reference rule: a load in EX blocks any real ID instruction that sources its rd.
    function automatic logic model_load_use();
        logic [4:0] srcs[$];
        if (use_rs1_id) srcs.push_back(rs1_id);
        if (use_rs2_id) srcs.push_back(rs2_id);
        if (!(model_ex.valid && model_ex.mr && model_ex.rd != 5'd0 && valid_id)) return 1'b0;
        foreach (srcs[k]) if (srcs[k] == model_ex.rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        return hold_ex || (model_load_use() && !flush_ex);
    endfunction

    task automatic model_edge();
        if (!rstn) begin
            model_ex  = '0;
            model_cnt = '0;
        end else if (!hold_ex) begin
            if (flush_ex || model_load_use()) begin
                model_ex  = '0;
                model_cnt = model_cnt + 32'd1;
            end else begin
                model_ex = '{valid: valid_id, pc: pc_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id,
                             d1: read_data1_id, d2: read_data2_id, imm: imm_id, ctrl: ctrl_id,
                             mr: valid_id && memread_id, mw: valid_id && memwrite_id,
                             rw: valid_id && regwrite_id};
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name);
        ex_t act;
        act = '{valid: valid_ex, pc: pc_ex, rs1: rs1_ex, rs2: rs2_ex, rd: rd_ex,
                d1: rs1_data_ex, d2: rs2_data_ex, imm: imm_ex, ctrl: ctrl_ex,
                mr: memread_ex, mw: memwrite_ex, rw: regwrite_ex};
        checks++;
        if (act !== model_ex) begin
            errors++;
            $display("[TB] FAIL %s ex_regs: got %h expected %h", name, act, model_ex);
        end
        check_val({name, " bubble_count"}, bubble_count, model_cnt);
    endtask

    // Inputs are already driven; checks stall before the edge and state after it.
    task automatic applyStimulus(input string name, input int exp_stall, input bit chk_stall);
        #1;
        if (chk_stall) check_val({name, " stall_model"}, {31'd0, stall_id}, {31'd0, model_stall()});
        if (exp_stall >= 0) check_val({name, " stall"}, {31'd0, stall_id}, exp_stall);
        model_edge();
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    task automatic random_inputs();
        valid_id      = ($urandom_range(0, 3) != 0);
        pc_id         = $urandom;
        rs1_id        = 5'($urandom_range(0, 3));
        rs2_id        = 5'($urandom_range(0, 3));
        rd_id         = 5'($urandom_range(0, 3));
        use_rs1_id    = 1'($urandom);
        use_rs2_id    = 1'($urandom);
        read_data1_id = $urandom;
        read_data2_id = $urandom;
        imm_id        = $urandom;
        ctrl_id       = CTRL_W'($urandom);
        memread_id    = 1'($urandom);
        memwrite_id   = 1'($urandom);
        regwrite_id   = 1'($urandom);
        flush_ex      = ($urandom_range(0, 7) == 0);
        hold_ex       = ($urandom_range(0, 7) == 0);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic mr, input logic fl, input logic hd);
        valid_id = v; pc_id = pc; rs1_id = r1; rs2_id = r2; rd_id = rd;
        use_rs1_id = u1; use_rs2_id = u2; memread_id = mr; memwrite_id = 1'b0;
        regwrite_id = 1'b1; flush_ex = fl; hold_ex = hd;
        read_data1_id = pc ^ 32'h1357_9BDF; read_data2_id = ~pc; imm_id = pc + 32'd8;
        ctrl_id = pc[CTRL_W-1:0] ^ 16'h5A5A;
    endtask

    initial begin
        logic [31:0] saved_cnt;
        //            valid pc          rs1 rs2 rd  u1 u2 mr rw fl  d1            d2            imm           stall val rd  pc          bubbles
        vecs[0]  = '{1'b1, 32'h100, 3,  4,  5,  1, 1, 0, 1, 0, 32'hAAAA5555, 32'h12345678, 32'hFFFFFFF0, 0, 1, 5,  32'h100, 0};
        vecs[1]  = '{1'b1, 32'h104, 2,  0,  5,  1, 0, 1, 1, 0, 32'h00000011, 32'h00000022, 32'h00000004, 0, 1, 5,  32'h104, 0};
        vecs[2]  = '{1'b1, 32'h108, 5,  7,  6,  1, 1, 0, 1, 0, 32'h00000033, 32'h00000044, 32'h00000000, 1, 0, 0,  32'h000, 1};
        vecs[3]  = '{1'b1, 32'h108, 5,  7,  6,  1, 1, 0, 1, 0, 32'h00000033, 32'h00000044, 32'h00000000, 0, 1, 6,  32'h108, 1};
        vecs[4]  = '{1'b1, 32'h10C, 1,  0,  0,  1, 0, 1, 1, 0, 32'h00000055, 32'h00000066, 32'h00000010, 0, 1, 0,  32'h10C, 1};
        vecs[5]  = '{1'b1, 32'h110, 0,  2,  8,  1, 1, 0, 1, 0, 32'h00000077, 32'h00000088, 32'h00000000, 0, 1, 8,  32'h110, 1};
        vecs[6]  = '{1'b1, 32'h114, 1,  0,  9,  1, 0, 1, 1, 0, 32'h00000099, 32'h000000AA, 32'h00000020, 0, 1, 9,  32'h114, 1};
        vecs[7]  = '{1'b1, 32'h118, 9,  3,  10, 0, 1, 0, 1, 0, 32'h000000BB, 32'h000000CC, 32'h00000000, 0, 1, 10, 32'h118, 1};
        vecs[8]  = '{1'b1, 32'h11C, 1,  0,  11, 1, 0, 1, 1, 0, 32'h000000DD, 32'h000000EE, 32'h00000030, 0, 1, 11, 32'h11C, 1};
        vecs[9]  = '{1'b1, 32'h120, 2,  11, 12, 1, 1, 0, 1, 1, 32'h000000FF, 32'h00000101, 32'h00000000, 0, 0, 0,  32'h000, 2};
        vecs[10] = '{1'b0, 32'h124, 1,  2,  13, 1, 1, 1, 1, 0, 32'h00000202, 32'h00000303, 32'h00000040, 0, 0, 13, 32'h124, 2};
        vecs[11] = '{1'b1, 32'h128, 1,  0,  14, 1, 0, 1, 1, 0, 32'h00000404, 32'h00000505, 32'h00000050, 0, 1, 14, 32'h128, 2};
        vecs[12] = '{1'b0, 32'h12C, 14, 0,  15, 1, 0, 0, 1, 0, 32'h00000606, 32'h00000707, 32'h00000000, 0, 0, 15, 32'h12C, 2};

        // Reset held for two edges with random inputs.
        rstn = 1'b0;
        random_inputs();
        applyStimulus("reset0", -1, 1'b0);
        random_inputs();
        applyStimulus("reset1", -1, 1'b1);
        check_val("reset bubble_count", bubble_count, 32'd0);
        check_val("reset valid_ex", {31'd0, valid_ex}, 32'd0);

        rstn = 1'b1;
        foreach (vecs[i]) begin
            set_id(vecs[i].valid, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].use1, vecs[i].use2, vecs[i].mr, vecs[i].flush, 1'b0);
            regwrite_id   = vecs[i].rw;
            read_data1_id = vecs[i].d1;
            read_data2_id = vecs[i].d2;
            imm_id        = vecs[i].imm;
            applyStimulus($sformatf("vec%0d", i), int'(vecs[i].exp_stall), 1'b1);
            check_val($sformatf("vec%0d valid_ex", i), {31'd0, valid_ex}, {31'd0, vecs[i].exp_valid});
            check_val($sformatf("vec%0d rd_ex", i), {27'd0, rd_ex}, {27'd0, vecs[i].exp_rd});
            check_val($sformatf("vec%0d pc_ex", i), pc_ex, vecs[i].exp_pc);
            check_val($sformatf("vec%0d bubbles", i), bubble_count, vecs[i].exp_bubbles);
        end
        check_val("passthru regwrite seq", {31'd0, regwrite_ex}, 32'd0);

        // Hold freezes EX even with a pending hazard and flush; flush acts once released.
        set_id(1'b1, 32'h200, 1, 0, 5, 1, 0, 1, 1'b0, 1'b0);
        applyStimulus("hold_load", 0, 1'b1);
        saved_cnt = bubble_count;
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 32'h300 + 32'(4 * k), 5, 2, 5'(6 + k), 1, 1, 0, 1'b1, 1'b1);
            applyStimulus($sformatf("hold%0d", k), 1, 1'b1);
            check_val($sformatf("hold%0d pc_ex", k), pc_ex, 32'h200);
            check_val($sformatf("hold%0d bubbles", k), bubble_count, saved_cnt);
        end
        hold_ex = 1'b0;
        applyStimulus("hold_release", 0, 1'b1);
        check_val("hold_release valid_ex", {31'd0, valid_ex}, 32'd0);
        check_val("hold_release bubbles", bubble_count, saved_cnt + 32'd1);

        // Reset in the middle of a load-use stall.
        set_id(1'b1, 32'h400, 1, 0, 7, 1, 0, 1, 1'b0, 1'b0);
        applyStimulus("mid_load", 0, 1'b1);
        set_id(1'b1, 32'h404, 3, 7, 8, 0, 1, 0, 1'b0, 1'b0);
        rstn = 1'b0;
        applyStimulus("mid_reset", 1, 1'b1);
        rstn = 1'b1;
        applyStimulus("after_reset", 0, 1'b1);
        check_val("after_reset pc_ex", pc_ex, 32'h404);

        // Counter wrap from all-ones.
        force dut.bubble_count = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_count;
        model_cnt = 32'hFFFF_FFFF;
        set_id(1'b1, 32'h500, 1, 2, 3, 1, 1, 0, 1'b1, 1'b0);
        applyStimulus("wrap", 0, 1'b1);
        check_val("wrap bubbles", bubble_count, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            random_inputs();
            rstn = ($urandom_range(0, 49) != 0);
            applyStimulus($sformatf("rand%0d", n), -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
